// File: rtl/noc_input_port_gen2_pkg.sv
// Shared types and elaboration-time helpers for the source-routed NoC input port.
package noc_input_port_gen2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    ROUTE,
    REQ,
    SEND_ADDR,
    SEND_PAY,
    DRAIN
  } state_t;

  localparam int MAX_PORTS = 32;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int addr_flits(input int addr_w, input int flit_w);
    return addr_w / flit_w;
  endfunction

  // One counter serves both header and payload phases, so size it for the longer one.
  function automatic int cnt_width(input int a_flits, input int p_flits);
    return clog2(((a_flits > p_flits) ? a_flits : p_flits) + 1);
  endfunction

  function automatic logic [MAX_PORTS-1:0] onehot(input logic [4:0] hop);
    return MAX_PORTS'(1) << hop;
  endfunction

endpackage

// File: rtl/noc_input_port_gen2_route_compute.sv
// Source-route decode: lowest hop field selects the output, remaining address shifts down.
// Latency: combinational. Backpressure: none.
// Out-of-range hop fields raise bad_hop and produce an empty request vector.
module noc_input_port_gen2_route_compute
  import noc_input_port_gen2_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int PSEL_W = 3,
  parameter int NPORTS = 5
) (
  input  logic [ADDR_W-1:0] cur_addr,
  output logic [PSEL_W-1:0] hop,
  output logic [ADDR_W-1:0] next_addr,
  output logic [NPORTS-1:0] req_onehot,
  output logic              bad_hop
);

  assign hop        = cur_addr[PSEL_W-1:0];
  assign next_addr  = cur_addr >> PSEL_W;
  assign bad_hop    = 32'(hop) >= NPORTS;
  assign req_onehot = bad_hop ? '0 : NPORTS'(onehot(5'(hop)));

endmodule

// File: rtl/noc_input_port_gen2.sv
// Router input port: pops header+payload from a show-ahead FIFO, routes, requests the arbiter, forwards.
// Latency: ROUTE then REQ cycle before the first output flit; REQ_BYPASS_EN removes the REQ cycle.
// Backpressure: stall or a full granted output freezes all state; an empty FIFO inserts bubbles.
module noc_input_port_gen2
  import noc_input_port_gen2_pkg::*;
#(
  parameter int FLIT_W        = 4,
  parameter int ADDR_W        = 16,
  parameter int PSEL_W        = 3,
  parameter int NPORTS        = 5,
  parameter int PAYLOAD_FLITS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic [FLIT_W-1:0] flit_in,
  output logic              read_fifo,
  input  logic              stall,
  input  logic              grant,
  input  logic [NPORTS-1:0] dest_full,
  output logic [NPORTS-1:0] req,
  output logic [PSEL_W-1:0] dest_port,
  output logic [FLIT_W-1:0] flit_out,
  output logic              flit_valid,
  output logic              arb_release,
  output logic              route_err
);

  localparam int ADDR_FLITS = addr_flits(ADDR_W, FLIT_W);
  localparam int CNT_W      = cnt_width(ADDR_FLITS, PAYLOAD_FLITS);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_FLITS - 1);
  localparam logic [CNT_W-1:0] PAY_LAST  = CNT_W'(PAYLOAD_FLITS - 1);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   cur_addr, nxt_addr, next_addr;
  logic [NPORTS-1:0]   req_reg, req_onehot;
  logic [CNT_W-1:0]    cnt;
  logic [PSEL_W-1:0]   hop;
  logic                bad_hop;
  logic                hold;

  noc_input_port_gen2_route_compute #(
    .ADDR_W (ADDR_W),
    .PSEL_W (PSEL_W),
    .NPORTS (NPORTS)
  ) u_route (
    .cur_addr   (cur_addr),
    .hop        (hop),
    .next_addr  (next_addr),
    .req_onehot (req_onehot),
    .bad_hop    (bad_hop)
  );

  // Only the output we are actually sending to can back-pressure us.
  assign hold = stall | (((state == SEND_ADDR) || (state == SEND_PAY)) && |(dest_full & req_reg));

  assign read_fifo   = !fifo_empty && !hold && (state inside {HDR, SEND_PAY, DRAIN});
  assign flit_valid  = (state == SEND_ADDR && !hold) || (state == SEND_PAY && read_fifo);
  assign flit_out    = (state == SEND_ADDR) ? nxt_addr[FLIT_W-1:0] :
                       (state == SEND_PAY)  ? flit_in : '0;
  assign arb_release = (state == SEND_PAY) && read_fifo && (cnt == PAY_LAST);
  assign route_err   = (state == ROUTE) && !hold && bad_hop;

`ifdef REQ_BYPASS_EN
  assign req = (state == ROUTE) ? req_onehot : req_reg;
`else
  assign req = req_reg;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!fifo_empty) state_nxt = HDR;
      HDR:       if (read_fifo && cnt == ADDR_LAST) state_nxt = ROUTE;
      ROUTE: begin
        if (bad_hop) state_nxt = DRAIN;
`ifdef REQ_BYPASS_EN
        else if (grant) state_nxt = SEND_ADDR;
`endif
        else state_nxt = REQ;
      end
      REQ:       if (grant) state_nxt = SEND_ADDR;
      SEND_ADDR: if (cnt == ADDR_LAST) state_nxt = SEND_PAY;
      SEND_PAY:  if (read_fifo && cnt == PAY_LAST) state_nxt = IDLE;
      DRAIN:     if (read_fifo && cnt == PAY_LAST) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    if (hold) state_nxt = state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_addr  <= '0;
      nxt_addr  <= '0;
      req_reg   <= '0;
      cnt       <= '0;
      dest_port <= '0;
    end else if (!hold) begin
      if (state_nxt != state)
        cnt <= '0;
      else if (read_fifo || state == SEND_ADDR)
        cnt <= cnt + 1'b1;
      // First header flit ends up in the LSBs after ADDR_FLITS right shifts.
      if (state == HDR && read_fifo)
        cur_addr <= {flit_in, cur_addr[ADDR_W-1:FLIT_W]};
      if (state == ROUTE) begin
        dest_port <= hop;
        req_reg   <= req_onehot;
        nxt_addr  <= next_addr;
      end
      if (state == SEND_ADDR)
        nxt_addr <= nxt_addr >> FLIT_W;
      if (arb_release)
        req_reg <= '0;
    end
  end

endmodule
